medium_data_reader: RTL and testbench

- Read-side companion to the team's 4-entry write-pointer byte buffer.
- Upstream writes bytes with a single `write_en` strobe.
- This block buffers them and drains them in order to a downstream consumer over a valid/ready handshake.
- It also flags each output byte whose low 3 bits fall in a configured match set (two codes), so the consumer can act on tagged bytes without re-decoding.

---
 rtl/medium_data_reader.sv | 85 ++++++++
 tb/tb_medium_data_reader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/medium_data_reader.sv
// Show-ahead byte buffer draining upstream writes to a valid/ready consumer,
// tagging bytes whose low 3 bits hit one of two configured codes.
module medium_data_reader #(
    parameter int         WIDTH   = 8,
    parameter int         DEPTH   = 4,
    parameter logic [2:0] MATCH_A = 3'b101,
    parameter logic [2:0] MATCH_B = 3'b111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_en,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       full,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_match,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             wr_acc;
    logic             pop;

    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign wr_acc    = write_en && !full;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // The drop decision uses the pre-edge occupancy even if a pop frees a slot.
        if (write_en && full) begin
            overflow_d = 1'b1;
        end
        if (wr_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not cleared on reset; empty-gating of data_out hides stale bytes.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_match = out_valid &&
                       ((data_out[2:0] == MATCH_A) || (data_out[2:0] == MATCH_B));
    assign count     = count_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_medium_data_reader.sv
// Bench for medium_data_reader: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_medium_data_reader;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       write_en;
    logic [7:0] data_in;
    logic       full;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic       out_match;
    logic [2:0] count;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    bit checking_en = 0;

    logic [7:0] mq[$];
    bit         m_overflow;

    medium_data_reader dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .data_in   (data_in),
        .full      (full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_match (out_match),
        .count     (count),
        .overflow  (overflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus a sticky drop flag.
    always @(posedge clk) begin
        bit was_full;
        bit do_pop;
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && out_ready;
        if (rst) begin
            mq.delete();
            m_overflow = 0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (write_en && !was_full) mq.push_back(data_in);
            if (write_en && was_full) m_overflow = 1;
        end
    end

    always @(negedge clk) begin
        if (checking_en) begin
            bit       ev;
            bit [7:0] ed;
            ev = (mq.size() != 0);
            ed = ev ? mq[0] : 8'h00;
            check("m_valid", out_valid, ev);
            check("m_data", data_out, ed);
            check("m_match", out_match, ev && (ed[2:0] == 3'b101 || ed[2:0] == 3'b111));
            check("m_count", count, mq.size());
            check("m_full", full, mq.size() == DEPTH);
            check("m_overflow", overflow, m_overflow);
        end
    end

    task automatic tick(input logic r, input logic we, input logic [7:0] d, input logic rdy);
        rst = r; write_en = we; data_in = d; out_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq [4];
        rst = 1; write_en = 0; data_in = 0; out_ready = 0;
        @(negedge clk);
        checking_en = 1;
        tick(0, 0, 8'h00, 0);

        // Reset then idle
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", data_out, 8'h00);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        tick(0, 0, 8'h00, 1);
        check("idle_ready_count", count, 0);

        // Single byte, stalled consumer
        tick(0, 1, 8'hA5, 0);
        check("a5_valid", out_valid, 1);
        check("a5_data", data_out, 8'hA5);
        check("a5_match", out_match, 1);
        check("a5_count", count, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 8'h00, 0);
            check("a5_hold", data_out, 8'hA5);
        end
        tick(0, 0, 8'h00, 1);
        check("a5_drained", out_valid, 0);

        // Fill then drain in order
        seq[0] = 8'h11; seq[1] = 8'h27; seq[2] = 8'h3C; seq[3] = 8'h4F;
        for (int i = 0; i < 4; i++) tick(0, 1, seq[i], 0);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", data_out, seq[i]);
            check("drain_match", out_match, (i == 1 || i == 3) ? 1 : 0);
            check("drain_count", count, 4 - i);
            tick(0, 0, 8'h00, 1);
        end
        check("drain_empty", out_valid, 0);

        // Drop on full even with a same-cycle pop
        for (int i = 1; i <= 4; i++) tick(0, 1, 8'(i), 0);
        tick(0, 1, 8'hFF, 1);
        check("drop_count", count, 3);
        check("drop_ovf", overflow, 1);
        check("drop_head", data_out, 8'h02);
        for (int i = 2; i <= 4; i++) begin
            check("drop_seq", data_out, 8'(i));
            tick(0, 0, 8'h00, 1);
        end
        check("drop_empty", out_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Steady write+pop at count=1 across two pointer wraps
        tick(0, 1, 8'h40, 0);
        for (int i = 0; i < 10; i++) begin
            check("stream_data", data_out, 8'h40 + 8'(i));
            check("stream_count", count, 1);
            tick(0, 1, 8'h41 + 8'(i), 1);
        end
        check("stream_last", data_out, 8'h4A);
        tick(0, 0, 8'h00, 1);

        // Reset mid-drain beats write and pop
        for (int i = 0; i < 3; i++) tick(0, 1, 8'h60 + 8'(i), 0);
        check("pre_rst_count", count, 3);
        tick(1, 1, 8'h99, 1);
        check("rst2_count", count, 0);
        check("rst2_valid", out_valid, 0);
        check("rst2_ovf", overflow, 0);
        tick(0, 1, 8'h05, 0);
        check("post_rst_data", data_out, 8'h05);
        check("post_rst_match", out_match, 1);
        tick(0, 0, 8'h00, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        checking_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
